result_dump_ctrl: RTL and testbench
===================================

// Module: result_dump_ctrl
// PURPOSE
//   Downstream consumer of the two-core processor's shared data memory. Waits until both
//   cores have raised endop, then borrows one data-memory read port. It reads the result
//   region word by word and streams it out on a valid/ready interface to the host/UART
//   bridge. It owns the memory port only while mem_req is high; the top level muxes the
//   address on mem_req.
// PARAMETERS
//   reg_width   12       data word width (matches core register width)
//   addr_width  12       data-memory address width
//   result_base 12'd2300 first address of the result region
//   result_len  12'd900  number of words to dump; 0 is legal (no beats)
// PORTS
//   clk            in   1           single clock; all state changes on posedge
//   reset          in   1           synchronous, active-high
//   start          in   1           same pulse that starts the cores; arms the dumper
//   endop_signal1  in   1           core1 finished (level or pulse; captured sticky)
//   endop_signal2  in   1           core2 finished (level or pulse; captured sticky)
//   mem_req        out  1           dumper owns the memory read port this cycle
//   mem_addr       out  addr_width  read address to data memory (valid when mem_req)
//   mem_rd_data    in   reg_width   memory read data, registered, 1-cycle latency
//   dump_valid     out  1           dump_data holds a valid word
//   dump_ready     in   1           sink accepts the word when dump_valid && dump_ready
//   dump_data      out  reg_width   result word
//   dump_last      out  1           high with the final word of the region
//   busy           out  1           high from arming until DONE
//   done           out  1           level, high in DONE
// BEHAVIOUR
//   Reset (sync): state=IDLE, flags cleared. All outputs are 0, including mem_addr and
//     dump_data.
//   States: IDLE, ARMED, FETCH, CAPT, OUT, DONE.
//   IDLE: start -> ARMED. The endop flags are cleared on entry.
//   ARMED: flag1|=endop_signal1, flag2|=endop_signal2. When both flags are set (including
//     both set in the same cycle, or one from an earlier cycle): if result_len==0 -> DONE,
//     else cnt=0 and -> FETCH.
//   FETCH: mem_req=1, mem_addr=result_base+cnt (mod 2^addr_width, wraps to 0) -> CAPT.
//   CAPT: mem_req=1 and address held. dump_data<=mem_rd_data, dump_valid<=1,
//     dump_last<=(cnt==result_len-1) -> OUT.
//   OUT: mem_req=0. dump_data, dump_valid and dump_last are held stable while !dump_ready.
//     On the handshake: dump_valid<=0, cnt<=cnt+1, then FETCH if not last, else DONE.
//   Throughput: at most 1 word per 3 cycles. First word is valid 2 cycles after
//     FETCH entry.
//   DONE: done=1, busy=0, mem_req=0. start -> ARMED (flags cleared, done cleared).
//     All other inputs are ignored.
//   busy=1 in ARMED/FETCH/CAPT/OUT.
//   start in ARMED/FETCH/CAPT/OUT is ignored; a dump is never restarted mid-stream.
//   endop edges after the flags are set are ignored.
//   dump_ready held high does not skip OUT; each word costs one OUT cycle minimum.
//   Reset mid-dump: the next cycle is IDLE with all outputs 0; any partial stream is
//     abandoned (the sink must discard it).
//   cnt width = addr_width. dump_last compare uses result_len-1 evaluated at addr_width bits.
// STRUCTURE
//   Shared header proc_defs.vh: state encoding localparams (3 bits) and the
//     RESULT_BASE/RESULT_LEN defaults, so the core, memory init and host tools agree.
//   One sub-module: dump_out_reg. It is a valid/ready holding register with
//     load/data/last inputs and stable-until-accepted outputs. The FSM and counter stay in
//     the top.
// TESTING
//   1 endop1 at cycle 10, endop2 at cycle 25, result_len=4, mem[2300..2303]=A,B,C,D,
//     ready=1 -> mem_req first at cycle 26. Beats A,B,C,D with dump_last only on D,
//     then done=1.
//   2 ready low for 5 cycles while word B is valid -> dump_data=B and dump_valid=1 held.
//     mem_req=0 during the stall. No B duplicate and no skip.
//   3 both endops in the same cycle -> FETCH next cycle. result_len=0 -> ARMED->DONE
//     directly, zero beats, mem_req never asserted.
//   4 result_base=12'hFFE, result_len=4 -> addresses FFE, FFF, 000, 001 in order.
//   5 reset asserted during OUT of word 2 -> next cycle all outputs 0, state IDLE.
//     Endops without start do not arm.
//   6 start pulse during the dump is ignored. After DONE, start plus both endops ->
//     second full identical stream.

Source files
------------

// File: rtl/result_dump_ctrl_pkg.sv
// Shared definitions for the result dumper: FSM encoding and the default
// location/size of the result region in data memory.
package result_dump_ctrl_pkg;

  localparam int default_reg_width   = 12;
  localparam int default_addr_width  = 12;
  localparam int default_result_base = 2300;
  localparam int default_result_len  = 900;

  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_armed = 3'd1,
    st_fetch = 3'd2,
    st_capt  = 3'd3,
    st_out   = 3'd4,
    st_done  = 3'd5
  } state_e;

endpackage

// File: rtl/result_dump_ctrl_if.sv
// Valid/ready stream carrying dumped result words toward the host/UART bridge.
interface result_dump_ctrl_if
  import result_dump_ctrl_pkg::*;
#(
  parameter int reg_width = default_reg_width
);

  logic                 dump_valid;
  logic                 dump_ready;
  logic [reg_width-1:0] dump_data;
  logic                 dump_last;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/result_dump_ctrl_dump_out_reg.sv
// Valid/ready holding register: a loaded word stays on the outputs, unchanged,
// until the sink accepts it.
module dump_out_reg #(
  parameter int width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic             last,
  output logic             fire
);

  assign fire = valid && ready;

  // Load a new word, or retire the current one on the handshake.
  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (fire) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/result_dump_ctrl.sv
// Result dumper: once both cores report endop, borrows a data-memory read port,
// walks the result region one word at a time and streams it out.
module result_dump_ctrl
  import result_dump_ctrl_pkg::*;
#(
  parameter int                    reg_width   = default_reg_width,
  parameter int                    addr_width  = default_addr_width,
  parameter logic [addr_width-1:0] result_base = addr_width'(default_result_base),
  parameter logic [addr_width-1:0] result_len  = addr_width'(default_result_len)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  endop_signal1,
  input  logic                  endop_signal2,
  output logic                  mem_req,
  output logic [addr_width-1:0] mem_addr,
  input  logic [reg_width-1:0]  mem_rd_data,
  result_dump_ctrl_if.master    dump,
  output logic                  busy,
  output logic                  done
);

  // Index of the final word; wraps to all-ones when result_len is 0, but that
  // case never leaves ARMED toward FETCH.
  localparam logic [addr_width-1:0] last_idx = result_len - 1'b1;

  state_e                state, state_next;
  logic                  flag1, flag2;
  logic [addr_width-1:0] cnt;
  logic                  both_set;
  logic                  is_last;
  logic                  load;
  logic                  fire;

  // Current-cycle endops count as well, so both arriving together arm at once.
  assign both_set = (flag1 | endop_signal1) & (flag2 | endop_signal2);
  assign is_last  = (cnt == last_idx);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= st_idle;
    else       state <= state_next;
  end

  // Sticky endop flags live only in ARMED; the word counter restarts there.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag1 <= 1'b0;
      flag2 <= 1'b0;
      cnt   <= '0;
    end else begin
      if (state == st_armed) begin
        flag1 <= flag1 | endop_signal1;
        flag2 <= flag2 | endop_signal2;
      end else begin
        flag1 <= 1'b0;
        flag2 <= 1'b0;
      end
      if (state == st_armed)           cnt <= '0;
      else if (state == st_out && fire) cnt <= cnt + 1'b1;
    end
  end

  // Next-state and memory-port control.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    load       = 1'b0;
    unique case (state)
      st_idle:  if (start) state_next = st_armed;
      st_armed: if (both_set) state_next = (result_len == '0) ? st_done : st_fetch;
      st_fetch: begin
        mem_req    = 1'b1;
        state_next = st_capt;
      end
      st_capt: begin
        mem_req    = 1'b1;
        load       = 1'b1;
        state_next = st_out;
      end
      st_out:   if (fire) state_next = is_last ? st_done : st_fetch;
      st_done:  if (start) state_next = st_armed;
      default:  state_next = st_idle;
    endcase
  end

  // Address is forced to zero whenever the port is not ours.
  assign mem_addr = mem_req ? (result_base + cnt) : '0;
  assign busy     = (state == st_armed) || (state == st_fetch) ||
                    (state == st_capt)  || (state == st_out);
  assign done     = (state == st_done);

  dump_out_reg #(
    .width(reg_width)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(mem_rd_data),
    .load_last(is_last),
    .ready    (dump.dump_ready),
    .valid    (dump.dump_valid),
    .data     (dump.dump_data),
    .last     (dump.dump_last),
    .fire     (fire)
  );

endmodule

// File: tb/tb_result_dump_ctrl.sv
// Bench for result_dump_ctrl: three instances share stimulus (normal region,
// region wrapping past the top of memory, empty region) and are checked
// against a memory-image reference of what each should stream.
module tb_result_dump_ctrl;

  localparam int max_ev = 32;
  localparam logic [11:0] base_tab [3] = '{12'd2300, 12'hFFE, 12'd2300};
  localparam int          len_tab  [3] = '{4, 4, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic endop1 = 1'b0;
  logic endop2 = 1'b0;
  logic ready = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [11:0] mem [4096];
  logic [11:0] rd_w [3];
  wire  [2:0]  req_w, v_w, l_w, busy_w, done_w;
  wire  [11:0] addr_w [3];
  wire  [11:0] d_w [3];

  result_dump_ctrl_if #(.reg_width(12)) dif0 ();
  result_dump_ctrl_if #(.reg_width(12)) dif1 ();
  result_dump_ctrl_if #(.reg_width(12)) dif2 ();

  assign dif0.dump_ready = ready;
  assign dif1.dump_ready = ready;
  assign dif2.dump_ready = ready;
  assign v_w[0] = dif0.dump_valid;
  assign v_w[1] = dif1.dump_valid;
  assign v_w[2] = dif2.dump_valid;
  assign l_w[0] = dif0.dump_last;
  assign l_w[1] = dif1.dump_last;
  assign l_w[2] = dif2.dump_last;
  assign d_w[0] = dif0.dump_data;
  assign d_w[1] = dif1.dump_data;
  assign d_w[2] = dif2.dump_data;

  result_dump_ctrl #(.reg_width(12), .addr_width(12), .result_base(12'd2300), .result_len(12'd4)) dut0 (
    .clk(clk), .reset(reset), .start(start), .endop_signal1(endop1), .endop_signal2(endop2),
    .mem_req(req_w[0]), .mem_addr(addr_w[0]), .mem_rd_data(rd_w[0]), .dump(dif0),
    .busy(busy_w[0]), .done(done_w[0]));

  result_dump_ctrl #(.reg_width(12), .addr_width(12), .result_base(12'hFFE), .result_len(12'd4)) dut1 (
    .clk(clk), .reset(reset), .start(start), .endop_signal1(endop1), .endop_signal2(endop2),
    .mem_req(req_w[1]), .mem_addr(addr_w[1]), .mem_rd_data(rd_w[1]), .dump(dif1),
    .busy(busy_w[1]), .done(done_w[1]));

  result_dump_ctrl #(.reg_width(12), .addr_width(12), .result_base(12'd2300), .result_len(12'd0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .endop_signal1(endop1), .endop_signal2(endop2),
    .mem_req(req_w[2]), .mem_addr(addr_w[2]), .mem_rd_data(rd_w[2]), .dump(dif2),
    .busy(busy_w[2]), .done(done_w[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered memory read, one cycle of latency.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) rd_w[g] <= mem[addr_w[g]];
  end

  // Event log: accepted beats, start of each memory request, protocol slips.
  int          nbeat [3] = '{0, 0, 0};
  int          nreq [3] = '{0, 0, 0};
  int          hold_err [3] = '{0, 0, 0};
  int          req_valid [3] = '{0, 0, 0};
  logic [11:0] beat_data [3][max_ev];
  logic        beat_last [3][max_ev];
  int          beat_cyc [3][max_ev];
  logic [11:0] req_addr [3][max_ev];
  int          req_cyc [3][max_ev];
  logic [2:0]  prev_req = '0;
  logic [2:0]  prev_valid = '0;
  logic [2:0]  prev_last = '0;
  logic [11:0] prev_data [3] = '{12'd0, 12'd0, 12'd0};
  logic        prev_ready = 1'b0;
  logic        prev_reset = 1'b1;

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (v_w[g] && ready) begin
        if (nbeat[g] < max_ev) begin
          beat_data[g][nbeat[g]] <= d_w[g];
          beat_last[g][nbeat[g]] <= l_w[g];
          beat_cyc[g][nbeat[g]]  <= cyc;
        end
        nbeat[g] <= nbeat[g] + 1;
      end
      if (req_w[g] && !prev_req[g]) begin
        if (nreq[g] < max_ev) begin
          req_addr[g][nreq[g]] <= addr_w[g];
          req_cyc[g][nreq[g]]  <= cyc;
        end
        nreq[g] <= nreq[g] + 1;
      end
      if (prev_valid[g] && !prev_ready && !prev_reset &&
          (!v_w[g] || d_w[g] !== prev_data[g] || l_w[g] !== prev_last[g]))
        hold_err[g] <= hold_err[g] + 1;
      if (req_w[g] && v_w[g]) req_valid[g] <= req_valid[g] + 1;
      prev_req[g]   <= req_w[g];
      prev_valid[g] <= v_w[g];
      prev_last[g]  <= l_w[g];
      prev_data[g]  <= d_w[g];
    end
    prev_ready <= ready;
    prev_reset <= reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, g, obs, exp);
    end
  endtask

  // Reference: word i of a region is the memory image at (base + i) mod 4096.
  function automatic logic [11:0] exp_addr(input logic [11:0] base, input int i);
    return base + 12'(i);
  endfunction

  function automatic logic [11:0] exp_word(input logic [11:0] base, input int i);
    return mem[exp_addr(base, i)];
  endfunction

  task automatic check_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      check({tag, "_mem_req"}, g, req_w[g], 0);
      check({tag, "_mem_addr"}, g, addr_w[g], 0);
      check({tag, "_valid"}, g, v_w[g], 0);
      check({tag, "_data"}, g, d_w[g], 0);
      check({tag, "_last"}, g, l_w[g], 0);
      check({tag, "_busy"}, g, busy_w[g], 0);
      check({tag, "_done"}, g, done_w[g], 0);
    end
  endtask

  task automatic wait_done(input int g, input int limit, input string tag);
    int k = 0;
    while (!done_w[g] && k < limit) begin
      tick();
      k++;
    end
    check({tag, "_done_reached"}, g, done_w[g], 1);
    check({tag, "_busy_in_done"}, g, busy_w[g], 0);
  endtask

  task automatic check_stream(input int g, input int b0, input int r0, input string tag);
    int len = len_tab[g];
    check({tag, "_beat_count"}, g, nbeat[g] - b0, len);
    check({tag, "_req_count"}, g, nreq[g] - r0, len);
    for (int i = 0; i < len && b0 + i < max_ev && r0 + i < max_ev; i++) begin
      check({tag, "_data"}, g, beat_data[g][b0 + i], exp_word(base_tab[g], i));
      check({tag, "_last"}, g, beat_last[g][b0 + i], (i == len - 1) ? 1 : 0);
      check({tag, "_addr"}, g, req_addr[g][r0 + i], exp_addr(base_tab[g], i));
    end
  endtask

  // Start, both endops in one cycle, ready held high, full stream on each DUT.
  task automatic run_full(input string tag);
    int b [3];
    int r [3];
    int e;
    for (int g = 0; g < 3; g++) begin
      b[g] = nbeat[g];
      r[g] = nreq[g];
    end
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check({tag, "_armed_busy"}, g, busy_w[g], 1);
      check({tag, "_armed_done"}, g, done_w[g], 0);
    end
    endop1 = 1'b1;
    endop2 = 1'b1;
    e = cyc;
    tick();
    endop1 = 1'b0;
    endop2 = 1'b0;
    check({tag, "_fetch_next_cycle"}, 0, req_w[0], 1);
    check({tag, "_empty_done_next_cycle"}, 2, done_w[2], 1);
    wait_done(0, 60, tag);
    wait_done(1, 60, tag);
    for (int g = 0; g < 3; g++) check_stream(g, b[g], r[g], tag);
    if (r[0] < max_ev) check({tag, "_first_req_cycle"}, 0, req_cyc[0][r[0]], e + 1);
    if (b[0] < max_ev) check({tag, "_first_beat_cycle"}, 0, beat_cyc[0][b[0]], e + 3);
    for (int i = 1; i < 4 && b[0] + i < max_ev; i++)
      check({tag, "_beat_spacing"}, 0, beat_cyc[0][b[0] + i] - beat_cyc[0][b[0] + i - 1], 3);
  endtask

  initial begin
    int s;
    int e2;
    int k;
    int b [3];
    int r [3];

    for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);

    // Reset values, then idle after release.
    reset = 1'b1;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    check_zero("idle");

    // Endops at +10 and +25 after start; a start pulse and a 5-cycle stall on
    // word B land mid-stream.
    for (int g = 0; g < 3; g++) begin
      b[g] = nbeat[g];
      r[g] = nreq[g];
    end
    ready = 1'b1;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    while (cyc < s + 10) tick();
    endop1 = 1'b1;
    tick();
    endop1 = 1'b0;
    while (cyc < s + 25) tick();
    check("armed_busy_one_endop", 0, busy_w[0], 1);
    check("no_req_one_endop", 0, nreq[0], r[0]);
    endop2 = 1'b1;
    e2 = cyc;
    tick();
    endop2 = 1'b0;
    check("req_after_endop2", 0, req_w[0], 1);
    check("empty_region_done", 2, done_w[2], 1);

    k = 0;
    while (nbeat[0] == b[0] && k < 20) begin
      tick();
      k++;
    end
    check("first_beat_seen", 0, nbeat[0], b[0] + 1);
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!v_w[0] && k < 10) begin
      tick();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 0, v_w[0], 1);
      check("stall_data", 0, d_w[0], exp_word(base_tab[0], 1));
      check("stall_last", 0, l_w[0], 0);
      check("stall_mem_req", 0, req_w[0], 0);
      check("stall_data", 1, d_w[1], exp_word(base_tab[1], 1));
      tick();
    end
    ready = 1'b1;
    wait_done(0, 60, "s1");
    wait_done(1, 60, "s1");
    for (int g = 0; g < 3; g++) check_stream(g, b[g], r[g], "s1");
    if (r[0] < max_ev) check("s1_first_req_cycle", 0, req_cyc[0][r[0]], e2 + 1);
    if (b[0] < max_ev) check("s1_first_beat_cycle", 0, beat_cyc[0][b[0]], e2 + 3);

    // After DONE: restart with both endops together, identical stream.
    run_full("s2");

    // Reset while word 2 waits in OUT; endops without start must not arm.
    for (int g = 0; g < 3; g++) b[g] = nbeat[g];
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    endop1 = 1'b1;
    endop2 = 1'b1;
    tick();
    endop1 = 1'b0;
    endop2 = 1'b0;
    k = 0;
    while (nbeat[0] == b[0] && k < 20) begin
      tick();
      k++;
    end
    ready = 1'b0;
    k = 0;
    while (!v_w[0] && k < 10) begin
      tick();
      k++;
    end
    check("s3_word2_valid", 0, v_w[0], 1);
    check("s3_word2_data", 0, d_w[0], exp_word(base_tab[0], 1));
    reset = 1'b1;
    tick();
    check_zero("s3_mid_reset");
    reset = 1'b0;
    tick();
    for (int g = 0; g < 3; g++) r[g] = nreq[g];
    endop1 = 1'b1;
    endop2 = 1'b1;
    tick();
    endop1 = 1'b0;
    endop2 = 1'b0;
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      check("s3_no_arm_busy", g, busy_w[g], 0);
      check("s3_no_arm_done", g, done_w[g], 0);
      check("s3_no_arm_req", g, nreq[g], r[g]);
    end

    // Recovery after the abandoned stream.
    run_full("s4");

    for (int g = 0; g < 3; g++) begin
      check("hold_violations", g, hold_err[g], 0);
      check("req_while_valid", g, req_valid[g], 0);
    end
    check("empty_region_never_req", 2, nreq[2], 0);
    check("empty_region_never_beat", 2, nbeat[2], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
